axis_be_stats_slice: RTL and testbench
======================================

# axis_be_stats_slice

Registered AXI4-Stream slice with full-throughput skid buffering, placed directly downstream of the little-to-big-endian bridge on the big-endian side of the datapath. It passes data, strobe, user and last unchanged, restores correct ready/valid backpressure semantics with registered ready, and keeps saturating packet, byte and strobe-error counters for the big-endian stream.

## Interface
Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width; multiple of 8
- C_AXIS_TUSER_WIDTH, 128, tuser width
- C_CNT_WIDTH, 32, width of each statistics counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  big-endian data from bridge
- s_axis_tstrb  in  C_AXIS_DATA_WIDTH/8  byte strobes; MSB = first byte
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  sideband
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  registered ready
- s_axis_tlast  in  1  last beat of packet
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  data out
- m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  strobes out
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  sideband out
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last out
- clear_stats  in  1  synchronous clear of all counters
- pkt_count  out  C_CNT_WIDTH  accepted tlast beats
- byte_count  out  C_CNT_WIDTH  sum of set tstrb bits of accepted beats
- err_count  out  C_CNT_WIDTH  accepted beats with illegal tstrb

## Operation
- Beat accepted at input when s_axis_tvalid && s_axis_tready; at output when m_axis_tvalid && m_axis_tready.
- Storage: output register (OUT) and one skid register (SKID), each holding {tdata, tstrb, tuser, tlast}.
- States: EMPTY (nothing held), ONE (OUT valid), FULL (OUT and SKID valid).
  - EMPTY: input accept -> load OUT, go ONE.
  - ONE: input accept and no output accept -> load SKID, go FULL; output accept and no input accept -> EMPTY; both -> reload OUT, stay ONE.
  - FULL: s_axis_tready is 0; output accept -> OUT <= SKID, go ONE.
- s_axis_tready registered: 1 in EMPTY/ONE, 0 in FULL, 0 while reset asserted.
- m_axis_tvalid = 1 in ONE and FULL. Beat order preserved; no beat dropped or duplicated.
- Strobe legality (big-endian, MSB-aligned): non-last beat must be all ones; last beat must be nonzero with contiguous ones from bit MSB downward (e.g. 0xFFFF_0000 legal, 0x0000_FFFF and 0xFF00_FF00 illegal for 32 strobes).
- On each input accept: byte_count += popcount(s_axis_tstrb); pkt_count += 1 if s_axis_tlast; err_count += 1 if strobe illegal. Illegal beats still forwarded and still counted in bytes.
- Counters saturate at all-ones; no wrap.
- clear_stats: all three counters read 0 next cycle; clear wins over a simultaneous increment. Data path unaffected.

## Timing
- Reset (async assert): state EMPTY; s_axis_tready, m_axis_tvalid, m_axis_tlast 0; m_axis_tdata/tstrb/tuser 0; all counters 0. Held beats discarded.
- First rising edge after reset deasserts: s_axis_tready -> 1.
- Latency: input accept at edge N -> beat on m_axis at edge N (visible after N), i.e. one register stage.
- Throughput: one beat per cycle when m_axis_tready held 1.
- m_axis_tready drop: at most one further beat accepted (into SKID), then s_axis_tready 0 the following cycle.
- m_axis outputs stable while m_axis_tvalid && !m_axis_tready.
- Counters update one cycle after the accepting edge.

## Test plan
- Reset then stream 4 beats, tstrb 0xFFFFFFFF, last beat 0xFFFF0000 tlast=1, m_axis_tready=1 -> output identical, 1-cycle latency, pkt_count=1, byte_count=112, err_count=0.
- Continuous stream, m_axis_tready deasserted 3 cycles mid-packet -> exactly one beat in SKID, s_axis_tready 0 one cycle after, no loss/reorder, full rate resumes.
- Last beat tstrb 0x0000FFFF, then non-last beat 0xFFFFFFFE -> err_count=2, byte_count increases by 47, both beats forwarded.
- Preload byte_count near saturation (force, or 2^C_CNT_WIDTH/32 beats with small C_CNT_WIDTH=8) -> byte_count sticks at 0xFF.
- clear_stats asserted same cycle as accepted tlast beat -> all counters 0 next cycle.
- Assert reset while FULL -> outputs/counters 0 immediately, s_axis_tready 1 one edge after release, no held beat emitted.

Source files
------------

// File: rtl/axis_be_stats_slice.sv
// Registered AXI4-Stream skid slice for the big-endian side of the bridge.
// Forwards beats unchanged and keeps saturating packet, byte and strobe-error counters.
module axis_be_stats_slice #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    input  logic                            clear_stats,
    output logic [C_CNT_WIDTH-1:0]          pkt_count,
    output logic [C_CNT_WIDTH-1:0]          byte_count,
    output logic [C_CNT_WIDTH-1:0]          err_count
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int POP_W  = $clog2(STRB_W + 1);
    localparam int SUM_W  = ((C_CNT_WIDTH > POP_W) ? C_CNT_WIDTH : POP_W) + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                          state_r;
    logic                            ready_r;
    logic                            valid_r;
    logic [C_AXIS_DATA_WIDTH-1:0]    out_data_r;
    logic [STRB_W-1:0]               out_strb_r;
    logic [C_AXIS_TUSER_WIDTH-1:0]   out_user_r;
    logic                            out_last_r;
    logic [C_AXIS_DATA_WIDTH-1:0]    skid_data_r;
    logic [STRB_W-1:0]               skid_strb_r;
    logic [C_AXIS_TUSER_WIDTH-1:0]   skid_user_r;
    logic                            skid_last_r;
    logic [C_CNT_WIDTH-1:0]          pkt_cnt_r;
    logic [C_CNT_WIDTH-1:0]          byte_cnt_r;
    logic [C_CNT_WIDTH-1:0]          err_cnt_r;

    logic                            in_acc_s;
    logic                            out_acc_s;
    logic                            beat_legal_s;
    logic [POP_W-1:0]                beat_pop_s;

    function automatic logic [POP_W-1:0] popcount(input logic [STRB_W-1:0] strb);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < STRB_W; i++) begin
            cnt = cnt + POP_W'(strb[i]);
        end
        return cnt;
    endfunction

    // Last beat: ones packed from the MSB means the inverted strobe is of the form 2^k-1.
    function automatic logic strb_legal(input logic [STRB_W-1:0] strb, input logic last);
        logic [STRB_W-1:0] inv;
        inv = ~strb;
        if (last) begin
            return (strb != '0) && ((inv & (inv + STRB_W'(1'b1))) == '0);
        end else begin
            return strb == '1;
        end
    endfunction

    function automatic logic [C_CNT_WIDTH-1:0] sat_add(input logic [C_CNT_WIDTH-1:0] cnt,
                                                       input logic [POP_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + SUM_W'(inc);
        if (sum > SUM_W'({C_CNT_WIDTH{1'b1}})) begin
            return {C_CNT_WIDTH{1'b1}};
        end else begin
            return sum[C_CNT_WIDTH-1:0];
        end
    endfunction

    assign in_acc_s     = s_axis_tvalid & ready_r;
    assign out_acc_s    = valid_r & m_axis_tready;
    assign beat_legal_s = strb_legal(s_axis_tstrb, s_axis_tlast);
    assign beat_pop_s   = popcount(s_axis_tstrb);

    // Occupancy FSM with OUT/SKID storage; ready is derived from the next state so it is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            ready_r     <= 1'b0;
            valid_r     <= 1'b0;
            out_data_r  <= '0;
            out_strb_r  <= '0;
            out_user_r  <= '0;
            out_last_r  <= 1'b0;
            skid_data_r <= '0;
            skid_strb_r <= '0;
            skid_user_r <= '0;
            skid_last_r <= 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    ready_r <= 1'b1;
                    if (in_acc_s) begin
                        out_data_r <= s_axis_tdata;
                        out_strb_r <= s_axis_tstrb;
                        out_user_r <= s_axis_tuser;
                        out_last_r <= s_axis_tlast;
                        valid_r    <= 1'b1;
                        state_r    <= ST_ONE;
                    end else begin
                        state_r    <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_acc_s && !out_acc_s) begin
                        skid_data_r <= s_axis_tdata;
                        skid_strb_r <= s_axis_tstrb;
                        skid_user_r <= s_axis_tuser;
                        skid_last_r <= s_axis_tlast;
                        ready_r     <= 1'b0;
                        state_r     <= ST_FULL;
                    end else if (out_acc_s && !in_acc_s) begin
                        valid_r     <= 1'b0;
                        state_r     <= ST_EMPTY;
                    end else if (in_acc_s && out_acc_s) begin
                        out_data_r  <= s_axis_tdata;
                        out_strb_r  <= s_axis_tstrb;
                        out_user_r  <= s_axis_tuser;
                        out_last_r  <= s_axis_tlast;
                    end else begin
                        state_r     <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_acc_s) begin
                        out_data_r <= skid_data_r;
                        out_strb_r <= skid_strb_r;
                        out_user_r <= skid_user_r;
                        out_last_r <= skid_last_r;
                        ready_r    <= 1'b1;
                        state_r    <= ST_ONE;
                    end else begin
                        state_r    <= ST_FULL;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b0;
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating statistics; a clear in the same cycle as an accept discards that beat's contribution.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_r  <= '0;
            byte_cnt_r <= '0;
            err_cnt_r  <= '0;
        end else if (clear_stats) begin
            pkt_cnt_r  <= '0;
            byte_cnt_r <= '0;
            err_cnt_r  <= '0;
        end else if (in_acc_s) begin
            pkt_cnt_r  <= sat_add(pkt_cnt_r, POP_W'(s_axis_tlast));
            byte_cnt_r <= sat_add(byte_cnt_r, beat_pop_s);
            err_cnt_r  <= sat_add(err_cnt_r, POP_W'(!beat_legal_s));
        end else begin
            pkt_cnt_r  <= pkt_cnt_r;
            byte_cnt_r <= byte_cnt_r;
            err_cnt_r  <= err_cnt_r;
        end
    end

    assign s_axis_tready = ready_r;
    assign m_axis_tvalid = valid_r;
    assign m_axis_tdata  = out_data_r;
    assign m_axis_tstrb  = out_strb_r;
    assign m_axis_tuser  = out_user_r;
    assign m_axis_tlast  = out_last_r;
    assign pkt_count     = pkt_cnt_r;
    assign byte_count    = byte_cnt_r;
    assign err_count     = err_cnt_r;

endmodule

// File: tb/tb_axis_be_stats_slice.sv
// Bench for axis_be_stats_slice: directed vector table, multi-cycle corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_axis_be_stats_slice;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int CW = 12;
    localparam int CNT_MAX = 4095;

    logic            clk;
    logic            reset;
    logic [DW-1:0]   s_axis_tdata;
    logic [DW/8-1:0] s_axis_tstrb;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tstrb;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic            clear_stats;
    logic [CW-1:0]   pkt_count;
    logic [CW-1:0]   byte_count;
    logic [CW-1:0]   err_count;

    axis_be_stats_slice #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .C_CNT_WIDTH       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tstrb (s_axis_tstrb),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .clear_stats  (clear_stats),
        .pkt_count    (pkt_count),
        .byte_count   (byte_count),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic [UW-1:0]   user;
        logic            last;
    } beat_t;

    typedef struct {
        logic        v;
        logic [31:0] st;
        logic        l;
        logic        mr;
        int          e_pkt;
        int          e_byte;
        int          e_err;
        logic        e_valid;
    } vec_t;

    beat_t q[$];
    int    m_pkt, m_byte, m_err;
    logic  exp_ready;
    int    acc_cnt;
    int    n_checks, n_fail;
    vec_t  tbl[7];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_strb(input logic [31:0] st, input logic l);
        int lead;
        lead = 0;
        if (!l) return st == 32'hFFFF_FFFF;
        for (int i = 31; i >= 0; i--) begin
            if (st[i]) lead++;
            else break;
        end
        return (lead > 0) && ($countones(st) == lead);
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_edge();
        bit in_acc, out_acc;
        beat_t b;
        in_acc  = s_axis_tvalid && exp_ready;
        out_acc = (q.size() != 0) && m_axis_tready;
        if (out_acc) void'(q.pop_front());
        if (in_acc) begin
            b.data = s_axis_tdata; b.strb = s_axis_tstrb;
            b.user = s_axis_tuser; b.last = s_axis_tlast;
            q.push_back(b);
            acc_cnt++;
        end
        if (clear_stats) begin
            m_pkt = 0; m_byte = 0; m_err = 0;
        end else if (in_acc) begin
            m_pkt  = sat(m_pkt + (s_axis_tlast ? 1 : 0));
            m_byte = sat(m_byte + $countones(s_axis_tstrb));
            m_err  = sat(m_err + (legal_strb(s_axis_tstrb, s_axis_tlast) ? 0 : 1));
        end
        exp_ready = (q.size() < 2);
    endtask

    task automatic check_outputs();
        chk("s_axis_tready", s_axis_tready, exp_ready);
        chk("m_axis_tvalid", m_axis_tvalid, q.size() != 0);
        if (q.size() != 0) begin
            chk("m_axis_tdata", m_axis_tdata, q[0].data);
            chk("m_axis_tstrb", m_axis_tstrb, q[0].strb);
            chk("m_axis_tuser", m_axis_tuser, q[0].user);
            chk("m_axis_tlast", m_axis_tlast, q[0].last);
        end
        chk("pkt_count", pkt_count, m_pkt);
        chk("byte_count", byte_count, m_byte);
        chk("err_count", err_count, m_err);
    endtask

    task automatic step(input logic v, input logic [31:0] st, input logic l,
                        input logic mr, input logic clr);
        s_axis_tvalid = v;
        s_axis_tstrb  = st;
        s_axis_tlast  = l;
        for (int i = 0; i < DW / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom();
        for (int i = 0; i < UW / 32; i++) s_axis_tuser[i*32 +: 32] = $urandom();
        m_axis_tready = mr;
        clear_stats   = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready"}, s_axis_tready, 1'b0);
        chk({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
        chk({tag, "_tlast"}, m_axis_tlast, 1'b0);
        chk({tag, "_tdata"}, m_axis_tdata, 256'd0);
        chk({tag, "_tstrb"}, m_axis_tstrb, 32'd0);
        chk({tag, "_tuser"}, m_axis_tuser, 128'd0);
        chk({tag, "_pkt"}, pkt_count, 12'd0);
        chk({tag, "_byte"}, byte_count, 12'd0);
        chk({tag, "_err"}, err_count, 12'd0);
    endtask

    function automatic logic [31:0] rand_strb();
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        case ($urandom_range(0, 3))
            0, 1:    return ones;
            2:       return ones << $urandom_range(0, 31);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        n_checks = 0; n_fail = 0; acc_cnt = 0;
        m_pkt = 0; m_byte = 0; m_err = 0; exp_ready = 1'b0;
        reset = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tstrb = '0;
        s_axis_tuser = '0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0; clear_stats = 1'b0;

        tbl[0] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 32,  0, 1'b1};
        tbl[1] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 64,  0, 1'b1};
        tbl[2] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, 96,  0, 1'b1};
        tbl[3] = '{1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 1, 112, 0, 1'b1};
        tbl[4] = '{1'b1, 32'h0000_FFFF, 1'b1, 1'b1, 2, 128, 1, 1'b1};
        tbl[5] = '{1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 2, 159, 2, 1'b1};
        tbl[6] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2, 159, 2, 1'b0};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Directed vectors: nominal packet, then illegal-strobe beats.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].st, tbl[i].l, tbl[i].mr, 1'b0);
            chk("tbl_pkt", pkt_count, tbl[i].e_pkt);
            chk("tbl_byte", byte_count, tbl[i].e_byte);
            chk("tbl_err", err_count, tbl[i].e_err);
            chk("tbl_valid", m_axis_tvalid, tbl[i].e_valid);
        end

        // Clear coinciding with an accepted tlast beat.
        step(1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 1'b1);
        chk("clr_pkt", pkt_count, 12'd0);
        chk("clr_byte", byte_count, 12'd0);
        chk("clr_err", err_count, 12'd0);
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("post_clr_byte", byte_count, 12'd32);

        // Backpressure: three cycles of m_axis_tready low mid-packet.
        repeat (3) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        acc_cnt = 0;
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_low", s_axis_tready, 1'b0);
        repeat (2) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        chk("bp_skid_accepts", acc_cnt, 1);
        acc_cnt = 0;
        repeat (4) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("bp_resume_accepts", acc_cnt, 3);
        step(1'b1, 32'hFF00_0000, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        // Byte counter saturation.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        repeat (130) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("sat_byte", byte_count, 12'hFFF);
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("sat_byte_hold", byte_count, 12'hFFF);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_strb(), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end

        // Reset while FULL: nothing held may come out afterwards.
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        chk("full_ready", s_axis_tready, 1'b0);
        chk("full_valid", m_axis_tvalid, 1'b1);
        #1 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        q.delete();
        m_pkt = 0; m_byte = 0; m_err = 0; exp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_release_ready", s_axis_tready, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_ready", s_axis_tready, 1'b1);
        chk("post_rst_valid", m_axis_tvalid, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
